// File: rtl/bridge_n.sv
// bridge_n: CPU-to-device bridge for NUM_DEV memory-mapped devices.
// Decodes a CPU load/store, runs a ready handshake with a wait-state
// timeout, generates byte lanes, extracts sub-word load data and
// registers the device interrupt lines.

package bridge_n_pkg;

    // Default device bases: device i sits at 0x7F00 + 16*i.
    function automatic logic [511:0] default_base(input int n);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                r[32*i +: 32] = 32'h0000_7F00 + (32'(i) * 32'd16);
            end else begin
                r[32*i +: 32] = 32'h0000_0000;
            end
        end
        return r;
    endfunction

endpackage

module bridge_n #(
    parameter int                      NUM_DEV  = 6,
    parameter logic [NUM_DEV*32-1:0]   DEV_BASE = (NUM_DEV*32)'(bridge_n_pkg::default_base(NUM_DEV)),
    parameter logic [NUM_DEV*32-1:0]   DEV_MASK = {NUM_DEV{32'hFFFF_FFF0}},
    parameter int                      TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [31:0]             addr,
    input  logic                    write_enable,
    input  logic [31:0]             write_data,
    input  logic [2:0]              dm_mode,
    output logic [31:0]             read_result,
    output logic                    valid,
    output logic                    err,
    output logic                    stop,
    output logic [NUM_DEV-1:0]      hwirq,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic [31:0]             dev_addr,
    output logic                    dev_we,
    output logic [3:0]              dev_be,
    output logic [31:0]             dev_wdata,
    input  logic [NUM_DEV*32-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ready,
    input  logic [NUM_DEV-1:0]      dev_irq
);

    localparam int         IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     addr_r;
    logic            we_r;
    logic [3:0]      be_r;
    logic [31:0]     wdata_r;
    logic [2:0]      mode_r;
    logic [IW-1:0]   idx_r;
    logic            err_r;
    logic [7:0]      cnt_r;
    logic [31:0]     rr_r;

    logic            hit_s;
    logic [IW-1:0]   idx_s;
    logic            legal_s;
    logic            aligned_s;
    logic            good_s;
    logic [3:0]      be_s;
    logic [31:0]     wdata_s;
    logic [31:0]     rd_s;
    logic            ready_s;
    logic [15:0]     half_s;
    logic [7:0]      byte_s;
    logic [31:0]     ext_s;

    // Address decode: scan downwards so the lowest matching index wins.
    always_comb begin
        hit_s = 1'b0;
        idx_s = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
                hit_s = 1'b1;
                idx_s = IW'(i);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Mode legality, alignment, byte lanes and lane-replicated store data.
    always_comb begin
        legal_s   = 1'b1;
        aligned_s = 1'b1;
        be_s      = 4'b0000;
        wdata_s   = 32'h0000_0000;
        case (dm_mode)
            3'd0: begin
                aligned_s = (addr[1:0] == 2'b00);
                be_s      = 4'b1111;
                wdata_s   = write_data;
            end
            3'd1, 3'd3: begin
                aligned_s = ~addr[0];
                be_s      = 4'b0011 << {addr[1], 1'b0};
                wdata_s   = {2{write_data[15:0]}};
            end
            3'd2, 3'd4: begin
                aligned_s = 1'b1;
                be_s      = 4'b0001 << addr[1:0];
                wdata_s   = {4{write_data[7:0]}};
            end
            default: begin
                legal_s   = 1'b0;
                aligned_s = 1'b0;
            end
        endcase
        good_s = hit_s & legal_s & aligned_s;
    end

    // Pick the selected device's read data and ready; others are ignored.
    always_comb begin
        rd_s    = 32'h0000_0000;
        ready_s = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_r == IW'(i)) begin
                rd_s    = dev_rdata[32*i +: 32];
                ready_s = dev_ready[i];
            end else begin
                ready_s = ready_s;
            end
        end
    end

    // Sub-word extraction with zero/sign extension for loads.
    always_comb begin
        half_s = addr_r[1] ? rd_s[31:16] : rd_s[15:0];
        case (addr_r[1:0])
            2'd0:    byte_s = rd_s[7:0];
            2'd1:    byte_s = rd_s[15:8];
            2'd2:    byte_s = rd_s[23:16];
            2'd3:    byte_s = rd_s[31:24];
            default: byte_s = 8'h00;
        endcase
        case (mode_r)
            3'd0:    ext_s = rd_s;
            3'd1:    ext_s = {16'h0000, half_s};
            3'd2:    ext_s = {24'h00_0000, byte_s};
            3'd3:    ext_s = {{16{half_s[15]}}, half_s};
            3'd4:    ext_s = {{24{byte_s[7]}}, byte_s};
            default: ext_s = 32'h0000_0000;
        endcase
    end

    // Access FSM: latch the request, wait for ready or timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            mode_r  <= 3'd0;
            idx_r   <= '0;
            err_r   <= 1'b0;
            cnt_r   <= 8'd0;
            rr_r    <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    cnt_r <= 8'd0;
                    if (req) begin
                        addr_r  <= addr;
                        we_r    <= write_enable;
                        be_r    <= be_s;
                        wdata_r <= wdata_s;
                        mode_r  <= dm_mode;
                        idx_r   <= idx_s;
                        if (good_s) begin
                            err_r <= 1'b0;
                            state <= BUSY;
                        end else begin
                            err_r <= 1'b1;
                            rr_r  <= 32'h0000_0000;
                            state <= RESP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (ready_s) begin
                        err_r <= 1'b0;
                        rr_r  <= we_r ? 32'h0000_0000 : ext_s;
                        state <= RESP;
                    end else if ((cnt_r + 8'd1) == TO) begin
                        // This was the last permitted wait cycle.
                        err_r <= 1'b1;
                        rr_r  <= 32'h0000_0000;
                        state <= RESP;
                    end else begin
                        state <= BUSY;
                    end
                end
                RESP: begin
                    cnt_r <= 8'd0;
                    state <= IDLE;
                end
                default: begin
                    cnt_r <= 8'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Interrupt lines: plain one-cycle register, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwirq <= '0;
        end else begin
            hwirq <= dev_irq;
        end
    end

    // Output decode from registered state; device bus is quiet outside BUSY.
    always_comb begin
        read_result = rr_r;
        valid       = (state == RESP);
        err         = (state == RESP) & err_r;
        stop        = ((state == IDLE) & req) | (state == BUSY);
        if (state == BUSY) begin
            dev_sel   = NUM_DEV'(1) << idx_r;
            dev_addr  = addr_r;
            dev_we    = we_r;
            dev_be    = be_r;
            dev_wdata = wdata_r;
        end else begin
            dev_sel   = '0;
            dev_addr  = 32'h0000_0000;
            dev_we    = 1'b0;
            dev_be    = 4'b0000;
            dev_wdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_bridge_n.sv
// Self-checking bench for bridge_n: accesses push expected responses into a
// scoreboard queue, a monitor pops and compares on every valid strobe.

module tb_bridge_n;

    localparam int N = 6;

    logic            clk;
    logic            rst;
    logic            req;
    logic [31:0]     addr;
    logic            write_enable;
    logic [31:0]     write_data;
    logic [2:0]      dm_mode;
    logic [31:0]     read_result;
    logic            valid;
    logic            err;
    logic            stop;
    logic [N-1:0]    hwirq;
    logic [N-1:0]    dev_sel;
    logic [31:0]     dev_addr;
    logic            dev_we;
    logic [3:0]      dev_be;
    logic [31:0]     dev_wdata;
    logic [N*32-1:0] dev_rdata;
    logic [N-1:0]    dev_ready;
    logic [N-1:0]    dev_irq;

    typedef struct {
        logic [31:0] rr;
        logic        er;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bridge_n #(.NUM_DEV(N)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .write_enable(write_enable), .write_data(write_data), .dm_mode(dm_mode),
        .read_result(read_result), .valid(valid), .err(err), .stop(stop),
        .hwirq(hwirq), .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we),
        .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ready(dev_ready), .dev_irq(dev_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every completion is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_read_result", read_result, e.rr);
                check_eq("sb_err", {31'd0, err}, {31'd0, e.er});
            end
        end
    end

    // One CPU access with a simple device model. dev<0 means no device hit;
    // waits<0 means the device never becomes ready; noise is asserted on
    // dev_ready throughout and must be ignored.
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [2:0] m, input int dev, input int waits,
                          input logic [31:0] rd, input logic [N-1:0] noise,
                          input logic [31:0] exp_rr, input logic exp_err, input int exp_lat,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t        e;
        logic [N-1:0] exp_sel;
        int          lat;
        bit          done;
        e.rr = exp_rr;
        e.er = exp_err;
        sb.push_back(e);
        exp_sel = (dev >= 0) ? (N'(1) << dev) : '0;
        lat  = 0;
        done = 1'b0;
        @(negedge clk);
        addr = a; write_enable = w; write_data = wd; dm_mode = m; req = 1'b1;
        dev_rdata = '0;
        if (dev >= 0) dev_rdata[32*dev +: 32] = rd;
        dev_ready = noise;
        #1;
        check_eq("stop_req_cycle", {31'd0, stop}, 32'd1);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            req = 1'b0;
            dev_ready = noise;
            if (valid === 1'b1) begin
                lat  = c;
                done = 1'b1;
                check_eq("latency", lat, exp_lat);
                check_eq("stop_resp", {31'd0, stop}, 32'd0);
            end else begin
                check_eq("dev_sel", {{(32-N){1'b0}}, dev_sel}, {{(32-N){1'b0}}, exp_sel});
                check_eq("stop_busy", {31'd0, stop}, 32'd1);
                if (c == 1) begin
                    check_eq("dev_addr", dev_addr, a);
                    check_eq("dev_we", {31'd0, dev_we}, {31'd0, w});
                    check_eq("dev_be", {28'd0, dev_be}, {28'd0, exp_be});
                    check_eq("dev_wdata", dev_wdata, exp_wd);
                end
                if (dev >= 0 && waits >= 0 && (c - 1) == waits) dev_ready[dev] = 1'b1;
            end
        end
        if (!done) check_eq("valid_timeout", 32'd0, 32'd1);
        dev_ready = '0;
        @(negedge clk);
        check_eq("valid_one_cycle", {31'd0, valid}, 32'd0);
        check_eq("err_cleared", {31'd0, err}, 32'd0);
        check_eq("read_result_hold", read_result, exp_rr);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; write_enable = 1'b0; write_data = '0;
        dm_mode = 3'd0; dev_rdata = '0; dev_ready = '0; dev_irq = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_stop", {31'd0, stop}, 32'd0);
        check_eq("rst_read_result", read_result, 32'd0);
        check_eq("rst_dev_sel", {26'd0, dev_sel}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word load, zero-wait, device 2
        access(32'h7F20, 1'b0, 32'h0, 3'd0, 2, 0, 32'hDEAD_BEEF, '0,
               32'hDEAD_BEEF, 1'b0, 2, 4'b1111, 32'h0);
        // Byte store to device 1 with two wait states
        access(32'h7F13, 1'b1, 32'h0000_00A5, 3'd2, 1, 2, 32'h1111_1111, '0,
               32'h0, 1'b0, 4, 4'b1000, 32'hA5A5_A5A5);
        // Signed and unsigned half loads from the upper half
        access(32'h7F02, 1'b0, 32'h0, 3'd3, 0, 0, 32'h8001_1234, '0,
               32'hFFFF_8001, 1'b0, 2, 4'b1100, 32'h0);
        access(32'h7F02, 1'b0, 32'h0, 3'd1, 0, 0, 32'h8001_1234, '0,
               32'h0000_8001, 1'b0, 2, 4'b1100, 32'h0);
        // Signed and unsigned byte loads from lane 1, one wait
        access(32'h7F11, 1'b0, 32'h0, 3'd4, 1, 1, 32'h1122_F344, '0,
               32'hFFFF_FFF3, 1'b0, 3, 4'b0010, 32'h0);
        access(32'h7F11, 1'b0, 32'h0, 3'd2, 1, 0, 32'h1122_F344, '0,
               32'h0000_00F3, 1'b0, 2, 4'b0010, 32'h0);
        // Half store to device 3, lower lanes
        access(32'h7F34, 1'b1, 32'h1234_BEEF, 3'd1, 3, 0, 32'h0, '0,
               32'h0, 1'b0, 2, 4'b0011, 32'hBEEF_BEEF);
        // Highest device, word load
        access(32'h7F5C, 1'b0, 32'h0, 3'd0, 5, 0, 32'hCAFE_F00D, '0,
               32'hCAFE_F00D, 1'b0, 2, 4'b1111, 32'h0);
        // Error requests: miss, misaligned word, illegal mode, misaligned half
        access(32'h0000_1234, 1'b0, 32'h0, 3'd0, -1, 0, 32'h0, '0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
        access(32'h7F01, 1'b0, 32'h0, 3'd0, -1, 0, 32'h0, '0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
        access(32'h7F00, 1'b0, 32'h0, 3'd6, -1, 0, 32'h0, '0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
        access(32'h7F23, 1'b0, 32'h0, 3'd3, -1, 0, 32'h0, '0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
        // Load 0x55.. first so the timeout zeroing of read_result is visible
        access(32'h7F40, 1'b0, 32'h0, 3'd0, 4, 0, 32'h5555_5555, '0,
               32'h5555_5555, 1'b0, 2, 4'b1111, 32'h0);
        // Timeout on device 0 while device 3 keeps asserting ready
        access(32'h7F04, 1'b0, 32'h0, 3'd0, 0, -1, 32'h7777_7777, 6'b001000,
               32'h0, 1'b1, 16, 4'b1111, 32'h0);

        // Asynchronous reset in the middle of a BUSY access
        dev_irq = 6'b010010;
        @(negedge clk);
        addr = 32'h7F00; write_enable = 1'b0; dm_mode = 3'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_sel", {26'd0, dev_sel}, 32'd1);
        check_eq("pre_rst_hwirq", {26'd0, hwirq}, 32'h12);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_dev_sel", {26'd0, dev_sel}, 32'd0);
        check_eq("arst_stop", {31'd0, stop}, 32'd0);
        check_eq("arst_valid", {31'd0, valid}, 32'd0);
        check_eq("arst_hwirq", {26'd0, hwirq}, 32'd0);
        dev_irq = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle_stop", {31'd0, stop}, 32'd0);

        // Interrupt lines appear one cycle later
        dev_irq = 6'b100001;
        #1;
        check_eq("hwirq_not_yet", {26'd0, hwirq}, 32'd0);
        @(negedge clk);
        check_eq("hwirq_registered", {26'd0, hwirq}, 32'h21);
        dev_irq = '0;
        @(negedge clk);
        check_eq("hwirq_level_drop", {26'd0, hwirq}, 32'd0);

        // Bridge still works after reset
        access(32'h7F20, 1'b0, 32'h0, 3'd0, 2, 0, 32'h0BAD_F00D, '0,
               32'h0BAD_F00D, 1'b0, 2, 4'b1111, 32'h0);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
